uart_regfile: RTL and testbench

- Register file on the downstream side of the UART command FSM. It consumes write_addr, write_data and the write strobe, and serves read_addr and the read strobe with registered read_data.
- Holds NUM_CFG 8-bit configuration registers that drive the chip.
- Also provides read-only status, sticky event flags (write-1-to-clear), an accepted-write counter, and a write-lock with a two-write unlock key.

---
 rtl/uart_regfile.sv | 135 +++++++++++++
 tb/tb_uart_regfile.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_regfile.sv
// Register file behind the UART command FSM: config registers, status/event/counter
// registers and a two-write unlock key, with a one-cycle registered read port.
module uart_regfile #(
    parameter int         NUM_CFG     = 16,
    parameter logic [7:0] CFG_DEFAULT = 8'h00,
    parameter logic [7:0] ID_VAL      = 8'h5C,
    parameter logic       LOCK_RESET  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           write_addr,
    input  logic [7:0]           write_data,
    input  logic                 write,
    input  logic [7:0]           read_addr,
    input  logic                 read,
    input  logic [7:0]           status_in,
    input  logic [7:0]           event_in,
    output logic [7:0]           read_data,
    output logic [NUM_CFG*8-1:0] cfg_bus,
    output logic                 cfg_changed,
    output logic                 locked
);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKED,
        ST_KEY1
    } lock_t;

    localparam logic [8:0] CFG_END    = 9'(NUM_CFG);
    localparam logic [7:0] ADDR_STAT  = 8'hF0;
    localparam logic [7:0] ADDR_EVENT = 8'hF1;
    localparam logic [7:0] ADDR_WRCNT = 8'hF2;
    localparam logic [7:0] ADDR_LOCK  = 8'hF3;
    localparam logic [7:0] ADDR_REJ   = 8'hF4;
    localparam logic [7:0] ADDR_ID    = 8'hFF;
    localparam logic [7:0] KEY_LOCK   = 8'hC3;
    localparam logic [7:0] KEY_FIRST  = 8'hA5;
    localparam logic [7:0] KEY_SECOND = 8'h5A;

    logic [7:0] cfg [NUM_CFG];
    logic       write_q;
    logic [7:0] status_q;
    logic [7:0] event_q;
    logic [7:0] wr_count;
    logic [7:0] rej_count;
    lock_t      lock_state;
    lock_t      lock_next;
    logic       accept;
    logic       cfg_hit;
    logic [7:0] event_clr;
    logic [7:0] rd_val;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    assign accept    = write & ~write_q;
    assign cfg_hit   = ({1'b0, write_addr} < CFG_END);
    assign event_clr = (accept && write_addr == ADDR_EVENT) ? write_data : 8'h00;

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_bus
        assign cfg_bus[8*g +: 8] = cfg[g];
    end

    // Any accepted write that is not the second key byte aborts a pending unlock.
    always_comb begin
        lock_next = lock_state;
        if (accept) begin
            if (write_addr == ADDR_LOCK) begin
                unique case (lock_state)
                    ST_UNLOCKED: lock_next = (write_data == KEY_LOCK)   ? ST_LOCKED   : ST_UNLOCKED;
                    ST_LOCKED:   lock_next = (write_data == KEY_FIRST)  ? ST_KEY1     : ST_LOCKED;
                    ST_KEY1:     lock_next = (write_data == KEY_SECOND) ? ST_UNLOCKED : ST_LOCKED;
                    default:     lock_next = ST_LOCKED;
                endcase
            end else if (lock_state == ST_KEY1) begin
                lock_next = ST_LOCKED;
            end
        end
    end

    always_comb begin
        rd_val = 8'h00;
        case (read_addr)
            ADDR_STAT:  rd_val = status_q;
            ADDR_EVENT: rd_val = event_q;
            ADDR_WRCNT: rd_val = wr_count;
            ADDR_LOCK:  rd_val = {7'b0, locked};
            ADDR_REJ:   rd_val = rej_count;
            ADDR_ID:    rd_val = ID_VAL;
            default:    rd_val = 8'h00;
        endcase
        for (int n = 0; n < NUM_CFG; n++) begin
            if (read_addr == 8'(n)) rd_val = cfg[n];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q     <= 1'b0;
            status_q    <= 8'h00;
            event_q     <= 8'h00;
            wr_count    <= 8'h00;
            rej_count   <= 8'h00;
            read_data   <= 8'h00;
            cfg_changed <= 1'b0;
            lock_state  <= LOCK_RESET ? ST_LOCKED : ST_UNLOCKED;
            locked      <= LOCK_RESET;
            for (int n = 0; n < NUM_CFG; n++) cfg[n] <= CFG_DEFAULT;
        end else begin
            write_q     <= write;
            status_q    <= status_in;
            cfg_changed <= 1'b0;
            lock_state  <= lock_next;
            locked      <= (lock_next != ST_UNLOCKED);
            // Set beats clear when an event lands in the same cycle as its W1C write.
            event_q     <= (event_q & ~event_clr) | event_in;
            if (read) read_data <= rd_val;
            if (accept && cfg_hit) begin
                if (locked) begin
                    rej_count <= sat_inc8(rej_count);
                end else begin
                    for (int n = 0; n < NUM_CFG; n++) begin
                        if (write_addr == 8'(n)) cfg[n] <= write_data;
                    end
                    wr_count    <= wr_count + 8'd1;
                    cfg_changed <= 1'b1;
                end
            end
            if (accept && write_addr == ADDR_REJ) rej_count <= 8'h00;
        end
    end

endmodule

// File: tb/tb_uart_regfile.sv
// Bench for uart_regfile: directed scenarios plus randomized traffic against a
// behavioural register-map model.
module tb_uart_regfile;

    localparam int         NUM_CFG     = 16;
    localparam logic [7:0] CFG_DEFAULT = 8'h00;
    localparam logic [7:0] ID_VAL      = 8'h5C;
    localparam logic       LOCK_RESET  = 1'b0;
    localparam int         BW          = NUM_CFG * 8;

    logic          clk;
    logic          reset;
    logic [7:0]    write_addr;
    logic [7:0]    write_data;
    logic          write;
    logic [7:0]    read_addr;
    logic          read;
    logic [7:0]    status_in;
    logic [7:0]    event_in;
    logic [7:0]    read_data;
    logic [BW-1:0] cfg_bus;
    logic          cfg_changed;
    logic          locked;

    uart_regfile #(
        .NUM_CFG(NUM_CFG), .CFG_DEFAULT(CFG_DEFAULT), .ID_VAL(ID_VAL), .LOCK_RESET(LOCK_RESET)
    ) dut (
        .clk(clk), .reset(reset), .write_addr(write_addr), .write_data(write_data),
        .write(write), .read_addr(read_addr), .read(read), .status_in(status_in),
        .event_in(event_in), .read_data(read_data), .cfg_bus(cfg_bus),
        .cfg_changed(cfg_changed), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int chg_seen = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: the register map as plain variables; lock mode 0=open, 1=locked, 2=key1 pending.
    logic [7:0] m_cfg [256];
    logic [7:0] m_wrc, m_rej, m_evt, m_status, m_rd;
    int         m_lock;
    logic       m_wq, m_chg;

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a < NUM_CFG) return m_cfg[a];
        case (a)
            8'hF0:   return m_status;
            8'hF1:   return m_evt;
            8'hF2:   return m_wrc;
            8'hF3:   return (m_lock != 0) ? 8'h01 : 8'h00;
            8'hF4:   return m_rej;
            8'hFF:   return ID_VAL;
            default: return 8'h00;
        endcase
    endfunction

    task automatic step();
        logic [BW-1:0] exp_bus;
        logic [7:0]    evt;
        if (reset) begin
            for (int i = 0; i < 256; i++) m_cfg[i] = CFG_DEFAULT;
            m_wrc = 0; m_rej = 0; m_evt = 0; m_status = 0; m_rd = 0;
            m_lock = LOCK_RESET ? 1 : 0; m_wq = 0; m_chg = 0;
        end else begin
            if (read) m_rd = m_read(read_addr);
            m_chg = 0;
            evt   = m_evt;
            if (write && !m_wq) begin
                if (write_addr < NUM_CFG) begin
                    if (m_lock != 0) m_rej = (m_rej == 8'hFF) ? 8'hFF : m_rej + 1;
                    else begin
                        m_cfg[write_addr] = write_data;
                        m_wrc = m_wrc + 1;
                        m_chg = 1;
                    end
                end else if (write_addr == 8'hF1) evt = evt & ~write_data;
                else if (write_addr == 8'hF4) m_rej = 0;
                if (write_addr == 8'hF3) begin
                    if (m_lock == 0)      m_lock = (write_data == 8'hC3) ? 1 : 0;
                    else if (m_lock == 1) m_lock = (write_data == 8'hA5) ? 2 : 1;
                    else                  m_lock = (write_data == 8'h5A) ? 0 : 1;
                end else if (m_lock == 2) m_lock = 1;
            end
            m_evt    = evt | event_in;
            m_status = status_in;
            m_wq     = write;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CFG; i++) exp_bus[8*i +: 8] = m_cfg[i];
        if (cfg_changed) chg_seen++;
        check("read_data", BW'(read_data), BW'(m_rd));
        check("locked", BW'(locked), BW'(m_lock != 0));
        check("cfg_changed", BW'(cfg_changed), BW'(m_chg));
        check("cfg_bus", cfg_bus, exp_bus);
    endtask

    task automatic idle(input int n);
        write = 0; read = 0; event_in = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold);
        write_addr = a; write_data = d; write = 1;
        for (int i = 0; i < hold; i++) step();
        write = 0;
        step();
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] a, input logic [7:0] exp);
        read_addr = a; read = 1;
        step();
        read = 0;
        check(tag, BW'(read_data), BW'(exp));
    endtask

    int c0;

    initial begin
        reset = 1; write = 0; read = 0; write_addr = 0; write_data = 0;
        read_addr = 0; status_in = 0; event_in = 0;
        step(); step();
        reset = 0;
        idle(1);

        rd_expect("rst_cfg0", 8'h00, CFG_DEFAULT);
        rd_expect("rst_id", 8'hFF, 8'h5C);
        rd_expect("rst_wrc", 8'hF2, 8'h00);
        check("rst_locked", BW'(locked), BW'(LOCK_RESET));

        c0 = chg_seen;
        do_write(8'h02, 8'h3C, 2);
        idle(1);
        check("chg_once", BW'(chg_seen - c0), BW'(1));
        rd_expect("cfg2", 8'h02, 8'h3C);
        rd_expect("wrc_one", 8'hF2, 8'h01);
        check("bus2", BW'(cfg_bus[23:16]), BW'(8'h3C));

        do_write(8'hF3, 8'hC3, 1);
        do_write(8'h02, 8'h11, 1);
        rd_expect("rej1", 8'hF4, 8'h01);
        rd_expect("cfg2_keep", 8'h02, 8'h3C);
        do_write(8'hF3, 8'hA5, 1);
        do_write(8'hF3, 8'h5A, 1);
        check("unlocked", BW'(locked), BW'(0));
        do_write(8'h02, 8'h11, 1);
        rd_expect("cfg2_new", 8'h02, 8'h11);

        do_write(8'hF4, 8'h00, 1);
        do_write(8'hF3, 8'hC3, 1);
        do_write(8'hF3, 8'hA5, 1);
        do_write(8'h05, 8'h66, 1);
        do_write(8'hF3, 8'h5A, 1);
        check("key_abort", BW'(locked), BW'(1));
        rd_expect("rej_abort", 8'hF4, 8'h01);
        rd_expect("cfg5_keep", 8'h05, CFG_DEFAULT);

        event_in = 8'h81; step(); event_in = 0;
        write_addr = 8'hF1; write_data = 8'h01; write = 1; event_in = 8'h01;
        step();
        write = 0; event_in = 0; step();
        rd_expect("evt_setwins", 8'hF1, 8'h81);
        do_write(8'hF1, 8'h81, 1);
        rd_expect("evt_clear", 8'hF1, 8'h00);

        do_write(8'hF3, 8'hA5, 1);
        do_write(8'hF3, 8'h5A, 1);
        do_write(8'h00, 8'h77, 1);
        rd_expect("cfg0_77", 8'h00, 8'h77);
        do_write(8'hF3, 8'hC3, 1);
        write_addr = 8'h07; write_data = 8'h99; write = 1;
        step();
        reset = 1; step(); reset = 0;
        step(); step(); step();
        write = 0; step();
        rd_expect("rst_cfg0_b", 8'h00, CFG_DEFAULT);
        rd_expect("rst_rej_b", 8'hF4, 8'h00);
        rd_expect("held_once", 8'hF2, 8'h01);
        rd_expect("held_cfg7", 8'h07, 8'h99);
        check("rst_locked_b", BW'(locked), BW'(LOCK_RESET));

        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 5)       write_addr = 8'($urandom_range(0, NUM_CFG - 1));
            else if (sel < 8)  write_addr = 8'($urandom_range(8'hF0, 8'hF4));
            else if (sel == 8) write_addr = 8'hFF;
            else               write_addr = 8'($urandom);
            case ($urandom_range(0, 4))
                0: write_data = 8'hC3;
                1: write_data = 8'hA5;
                2: write_data = 8'h5A;
                default: write_data = 8'($urandom);
            endcase
            write     = ($urandom_range(0, 2) != 0);
            read      = ($urandom_range(0, 1) != 0);
            read_addr = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, NUM_CFG + 2))
                                                    : 8'($urandom_range(8'hEE, 8'hFF));
            status_in = 8'($urandom);
            event_in  = 8'($urandom & $urandom & $urandom);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
